// File: rtl/coin_pulse_conditioner.sv
// coin_pulse_conditioner
// Front end of the coin datapath. It synchronizes and debounces four raw coin
// sensors and produces one clean 1-cycle pulse for each accepted coin, along
// with the coin's type and cent value. Glitches and multi-sensor jams are
// rejected.
// Optional feature: define COIN_TALLY_EN to enable the saturating per-type
// coin counters on the tally output. Without it, tally reads zero.
module coin_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  sensor_raw,
    output logic        coin_valid,
    output logic [1:0]  coin_type,
    output logic [4:0]  coin_cents,
    output logic        coin_error,
    output logic        busy,
    output logic [31:0] tally
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        EMIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_CYCLES);

    state_t           state;
    logic [3:0]       sync1;
    logic [3:0]       s;
    logic [1:0]       sel;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_done;
    logic             s_multi;
    logic [1:0]       s_idx;
    logic [3:0]       sel_hot;

    // Map a coin index to its cent value: 1c, 5c, 10c, 25c.
    function automatic logic [4:0] cents_of(input logic [1:0] idx);
        case (idx)
            2'd0:    cents_of = 5'd1;
            2'd1:    cents_of = 5'd5;
            2'd2:    cents_of = 5'd10;
            default: cents_of = 5'd25;
        endcase
    endfunction

    // Two-flop synchronizer for each raw sensor line.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1 <= 4'b0;
            s     <= 4'b0;
        end else begin
            sync1 <= sensor_raw;
            s     <= sync1;
        end
    end

    // Decode the synchronized vector and precompute the debounce counter step.
    always_comb begin
        cnt_inc  = cnt + CNT_W'(1);
        cnt_done = (cnt_inc == DB_TARGET);
        s_multi  = ((s & (s - 4'd1)) != 4'd0);
        sel_hot  = 4'b0001 << sel;
        s_idx    = 2'd0;
        case (s)
            4'b0010: s_idx = 2'd1;
            4'b0100: s_idx = 2'd2;
            4'b1000: s_idx = 2'd3;
            default: s_idx = 2'd0;
        endcase
    end

    // Debounce FSM. Every output is registered here and set on the edge
    // that enters the state the output describes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            sel        <= 2'd0;
            cnt        <= '0;
            coin_valid <= 1'b0;
            coin_type  <= 2'd0;
            coin_cents <= 5'd0;
            coin_error <= 1'b0;
            busy       <= 1'b0;
        end else begin
            coin_valid <= 1'b0;
            coin_type  <= 2'd0;
            coin_cents <= 5'd0;
            coin_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_multi) begin
                        state      <= RELEASE;
                        cnt        <= '0;
                        coin_error <= 1'b1;
                        busy       <= 1'b1;
                    end else if (s != 4'd0) begin
                        sel  <= s_idx;
                        busy <= 1'b1;
                        if (DEBOUNCE_CYCLES == 1) begin
                            state      <= EMIT;
                            cnt        <= '0;
                            coin_valid <= 1'b1;
                            coin_type  <= s_idx;
                            coin_cents <= cents_of(s_idx);
                        end else begin
                            state <= QUALIFY;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (s == sel_hot) begin
                        if (cnt_done) begin
                            state      <= EMIT;
                            cnt        <= '0;
                            coin_valid <= 1'b1;
                            coin_type  <= sel;
                            coin_cents <= cents_of(sel);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                EMIT: begin
                    state <= RELEASE;
                    cnt   <= '0;
                end
                RELEASE: begin
                    if (s != 4'd0) begin
                        cnt <= '0;
                    end else if (cnt_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef COIN_TALLY_EN
    logic [7:0] tally_cnt [4];

    // Saturating per-type counters. Each one advances the cycle after a pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                tally_cnt[i] <= 8'd0;
            end
        end else if (coin_valid && (tally_cnt[coin_type] != 8'hFF)) begin
            tally_cnt[coin_type] <= tally_cnt[coin_type] + 8'd1;
        end
    end

    assign tally = {tally_cnt[3], tally_cnt[2], tally_cnt[1], tally_cnt[0]};
`else
    assign tally = 32'h0;
`endif

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// tb_coin_pulse_conditioner
// Directed bench for coin_pulse_conditioner with DEBOUNCE_CYCLES = 4.
// It covers reset, a single coin, a glitch, a jam, a bouncy release, and a
// clear during a pulse. The tally checks adapt to COIN_TALLY_EN.
module tb_coin_pulse_conditioner;

    logic        clk;
    logic        clr;
    logic [3:0]  sensor_raw;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic [4:0]  coin_cents;
    logic        coin_error;
    logic        busy;
    logic [31:0] tally;

    int tests;
    int fails;
    int pulses;
    int errors;
    int saw_busy;

    coin_pulse_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .clr(clr),
        .sensor_raw(sensor_raw),
        .coin_valid(coin_valid),
        .coin_type(coin_type),
        .coin_cents(coin_cents),
        .coin_error(coin_error),
        .busy(busy),
        .tally(tally)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] raw);
        sensor_raw = raw;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Count pulses and errors over n edges, noting whether busy was ever seen.
    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (coin_valid) pulses++;
            if (coin_error) errors++;
            if (busy) saw_busy = 1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sensor_raw = 4'b0;
        clr = 1'b1;
        #3;
        checkOutput("reset_valid", {31'd0, coin_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_tally", tally, 32'd0);
        tick();
        tick();
        #2 clr = 1'b0;
        tick();

        // Single 10c coin held for 20 edges.
        applyStimulus(4'b0100);
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (coin_valid) pulses++;
            if (e == 4) checkOutput("single_valid_e4", {31'd0, coin_valid}, 32'd0);
            if (e == 5) begin
                checkOutput("single_valid_e5", {31'd0, coin_valid}, 32'd1);
                checkOutput("single_type", {30'd0, coin_type}, 32'd2);
                checkOutput("single_cents", {27'd0, coin_cents}, 32'd10);
            end
            if (e == 6) begin
                checkOutput("single_valid_e6", {31'd0, coin_valid}, 32'd0);
                checkOutput("single_cents_e6", {27'd0, coin_cents}, 32'd0);
            end
        end
        checkOutput("single_pulses", pulses, 32'd1);
        checkOutput("single_busy_held", {31'd0, busy}, 32'd1);
        applyStimulus(4'b0);
        repeat (8) tick();
        checkOutput("single_busy_end", {31'd0, busy}, 32'd0);
`ifndef COIN_TALLY_EN
        checkOutput("tally_disabled", tally, 32'd0);
`endif

        // Glitch: a 1c sensor high for only two cycles.
        applyStimulus(4'b0001);
        tick();
        tick();
        applyStimulus(4'b0);
        pulses = 0;
        errors = 0;
        saw_busy = 0;
        observe(10);
        checkOutput("glitch_pulses", pulses, 32'd0);
        checkOutput("glitch_errors", errors, 32'd0);
        checkOutput("glitch_saw_busy", saw_busy, 32'd1);
        checkOutput("glitch_busy_end", {31'd0, busy}, 32'd0);

        // Jam: two sensors high together.
        applyStimulus(4'b1010);
        pulses = 0;
        errors = 0;
        observe(12);
        checkOutput("jam_errors", errors, 32'd1);
        checkOutput("jam_pulses", pulses, 32'd0);
        checkOutput("jam_busy_held", {31'd0, busy}, 32'd1);
        applyStimulus(4'b0);
        repeat (5) tick();
        checkOutput("jam_busy_edge4", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("jam_busy_edge5", {31'd0, busy}, 32'd0);

        // Bouncy release after an accepted 25c coin.
        applyStimulus(4'b1000);
        pulses = 0;
        errors = 0;
        observe(8);
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0000 : 4'b1000);
            observe(1);
        end
        applyStimulus(4'b0);
        observe(10);
        checkOutput("bounce_pulses", pulses, 32'd1);
        checkOutput("bounce_busy_end", {31'd0, busy}, 32'd0);
        applyStimulus(4'b0010);
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 5) begin
                checkOutput("after_bounce_valid", {31'd0, coin_valid}, 32'd1);
                checkOutput("after_bounce_cents", {27'd0, coin_cents}, 32'd5);
                checkOutput("after_bounce_type", {30'd0, coin_type}, 32'd1);
            end
        end
        applyStimulus(4'b0);
        repeat (8) tick();

        // Clear asserted mid-cycle while a pulse is being presented.
        applyStimulus(4'b0001);
        repeat (6) tick();
        checkOutput("pre_clr_valid", {31'd0, coin_valid}, 32'd1);
        #2 clr = 1'b1;
        #1;
        checkOutput("clr_valid", {31'd0, coin_valid}, 32'd0);
        checkOutput("clr_cents", {27'd0, coin_cents}, 32'd0);
        checkOutput("clr_busy", {31'd0, busy}, 32'd0);
        applyStimulus(4'b0);
        tick();
        tick();
        #2 clr = 1'b0;
        tick();

`ifdef COIN_TALLY_EN
        // 300 1c coins with two 5c coins interleaved. 1c saturates at 255.
        for (int i = 0; i < 302; i++) begin
            applyStimulus((i == 100 || i == 200) ? 4'b0010 : 4'b0001);
            repeat (6) tick();
            applyStimulus(4'b0);
            repeat (7) tick();
        end
        checkOutput("tally_saturated", tally, 32'h0000_02FF);
        applyStimulus(4'b0001);
        repeat (3) tick();
        checkOutput("qualify_busy", {31'd0, busy}, 32'd1);
        #2 clr = 1'b1;
        #1;
        checkOutput("tally_clr", tally, 32'd0);
        checkOutput("qualify_clr_busy", {31'd0, busy}, 32'd0);
        applyStimulus(4'b0);
        tick();
        tick();
        #2 clr = 1'b0;
        pulses = 0;
        errors = 0;
        observe(10);
        checkOutput("qualify_clr_pulses", pulses, 32'd0);
        checkOutput("qualify_clr_tally", tally, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
